mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates one single-port instruction/data SRAM between the IF-stage fetch requester and the MEM-stage load/store requester.
- Sequences each access over a fixed SRAM read latency and routes the response back to the requester that issued it.
- Produces the stall request consumed by the pipeline stall controller whenever a requester is blocked or waiting for its response.
- Data side has priority; a fairness counter stops the data side from starving fetch.

Parameters:
LATENCY, 1, cycles from the grant cycle to read data on sram_rdata; legal range 1..4.
MAX_DATA_RUN, 2, consecutive data grants allowed while inst_req is pending before inst is forced; legal range 1..7.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
inst_req  in  1  fetch request; held until granted
inst_addr  in  32  fetch address
inst_gnt  out  1  fetch accepted this cycle
inst_rvalid  out  1  fetch data valid this cycle
inst_rdata  out  32  fetch data
data_req  in  1  load/store request; held until granted
data_we  in  4  byte write enables; 0 means load
data_addr  in  32  data address
data_wdata  in  32  store data
data_gnt  out  1  data access accepted this cycle
data_rvalid  out  1  load data, or store acknowledge, valid this cycle
data_rdata  out  32  load data; 0 for stores
sram_en  out  1  SRAM access strobe
sram_wen  out  4  SRAM byte write enables
sram_addr  out  32  SRAM address
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data
stallreq  out  1  pipeline stall request

Behaviour:
- **Reset values.** While rst is high, every output is 0 and state goes to IDLE. The beat counter, owner, run counter and any outstanding access are discarded, and no rvalid is issued for the dropped access.
- **States.**
  - IDLE: no access outstanding.
  - BUSY: one access outstanding, with registered owner (INST or DATA), registered write flag, and beat counter cnt.
- **Grant decision.** Combinational, made in IDLE, or in BUSY on the response cycle (see back-to-back below).
  - Priority: data_req wins, unless inst_req=1 and run_cnt==MAX_DATA_RUN, in which case inst wins.
  - Exactly one of inst_gnt and data_gnt may be 1 in a cycle.
- **SRAM drive in the grant cycle.** sram_en=1 and sram_addr comes from the granted requester. For inst, sram_wen=0 and sram_wdata=0. For data, sram_wen=data_we and sram_wdata=data_wdata. In non-grant cycles all sram_* outputs are 0.
- **Run counter (3 bits).**
  - Increments on a data grant while inst_req=1, saturating at MAX_DATA_RUN.
  - Clears on an inst grant, and in any cycle where inst_req=0.
- **Access sequencing.**
  - A grant loads owner, clears cnt to 1 and enters BUSY.
  - cnt increments each cycle in BUSY.
  - The response cycle is the cycle where cnt==LATENCY, i.e. grant cycle + LATENCY.
  - In the response cycle the owner's rvalid=1 and its rdata is sram_rdata, or 0 if the access was a write. The other requester's rvalid and rdata are 0.
- **Back-to-back.** In the response cycle the arbiter may grant a new request in the same cycle. With LATENCY=1 this gives one access per cycle. With no new grant in the response cycle, it returns to IDLE.
- **Ordering.** Responses return in grant order; only one access is ever outstanding.
- **stallreq.** stallreq = (inst_req & ~inst_gnt) | (data_req & ~data_gnt) | (BUSY & ~response cycle).
- **Simultaneous events.** A requester raising req in its own response cycle is eligible for grant in that same cycle. A request deasserted before grant is simply never served.
- **Widths.** cnt is 3 bits and run_cnt is 3 bits. There is no address arithmetic; addresses pass through unchanged.

Test Plan:
1. **Fetch stream, LATENCY=1.** inst_req held with addr 0x0, 0x4, 0x8, sram_rdata = addr+0x100 → inst_gnt every cycle; inst_rvalid one cycle after each grant with 0x100/0x104/0x108; stallreq=0 throughout.
2. **Simultaneous requests.** inst_req and data_req both rise, data load at 0x1000 → data_gnt first, inst_gnt in the data response cycle; stallreq=1 in the cycle inst is blocked.
3. **Fairness, MAX_DATA_RUN=2.** data_req and inst_req held for 4 data + 1 inst → grant order D,D,I,D,D.
4. **Latency stall, LATENCY=3.** Single inst_req → stallreq=1 for 2 cycles after grant; inst_rvalid at grant+3; no grant in between even with data_req high.
5. **Store.** data_we=4'b0011, addr 0x20, wdata 0xDEADBEEF → sram_wen=4'b0011, sram_wdata=0xDEADBEEF in grant cycle; data_rvalid at grant+LATENCY with data_rdata=0.
6. **Reset mid-access.** rst asserted the cycle after a LATENCY=3 grant → all outputs 0 next cycle; no rvalid ever returned for the dropped access; a fresh request after rst is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the SRAM and the
// single-port memory arbiter.
interface mem_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic [3:0]  data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    logic        stallreq;

    // Arbiter side
    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_we, data_addr, data_wdata,
        input  sram_rdata,
        output inst_gnt, inst_rvalid, inst_rdata,
        output data_gnt, data_rvalid, data_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata,
        output stallreq
    );

    // Requester / SRAM side
    modport master (
        output inst_req, inst_addr,
        output data_req, data_we, data_addr, data_wdata,
        output sram_rdata,
        input  inst_gnt, inst_rvalid, inst_rdata,
        input  data_gnt, data_rvalid, data_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata,
        input  stallreq
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and load/store.
// Data side has priority; a run counter forces a fetch grant after
// MAX_DATA_RUN consecutive data grants while fetch is waiting.
// One access is outstanding at a time; a new grant may overlap the
// response cycle of the previous one.
module mem_port_arbiter #(
    parameter int LATENCY      = 1,
    parameter int MAX_DATA_RUN = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [2:0] LAT_C = 3'(LATENCY);
    localparam logic [2:0] MAX_C = 3'(MAX_DATA_RUN);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OWN_INST, OWN_DATA} owner_t;

    state_t     state;
    owner_t     owner;
    logic       wr_q;
    logic [2:0] cnt;
    logic [2:0] run_cnt;

    logic resp;
    logic can_grant;
    logic force_inst;
    logic data_win;
    logic inst_win;

    // Grant decision: allowed when idle or when the outstanding access responds
    always_comb begin
        resp       = (state == BUSY) && (cnt == LAT_C);
        can_grant  = (state == IDLE) || resp;
        force_inst = bus.inst_req && (run_cnt == MAX_C);
        data_win   = can_grant && bus.data_req && !force_inst;
        inst_win   = can_grant && bus.inst_req && !data_win;
    end

    // Access sequencer: owner, write flag and beat counter of the outstanding access
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= OWN_INST;
            wr_q  <= 1'b0;
            cnt   <= 3'd0;
        end else if (inst_win || data_win) begin
            state <= BUSY;
            owner <= data_win ? OWN_DATA : OWN_INST;
            wr_q  <= data_win && (bus.data_we != 4'd0);
            cnt   <= 3'd1;
        end else if (resp) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else if (state == BUSY) begin
            cnt   <= cnt + 3'd1;
        end
    end

    // Fairness: count data grants that overtake a waiting fetch
    always_ff @(posedge clk) begin
        if (rst || !bus.inst_req) begin
            run_cnt <= 3'd0;
        end else if (inst_win) begin
            run_cnt <= 3'd0;
        end else if (data_win && (run_cnt != MAX_C)) begin
            run_cnt <= run_cnt + 3'd1;
        end
    end

    // Grants and SRAM drive; everything forced low while in reset
    assign bus.inst_gnt   = !rst && inst_win;
    assign bus.data_gnt   = !rst && data_win;
    assign bus.sram_en    = !rst && (inst_win || data_win);
    assign bus.sram_wen   = (!rst && data_win) ? bus.data_we : 4'd0;
    assign bus.sram_wdata = (!rst && data_win) ? bus.data_wdata : 32'd0;
    assign bus.sram_addr  = rst      ? 32'd0 :
                            data_win ? bus.data_addr :
                            inst_win ? bus.inst_addr : 32'd0;

    // Response routing to the requester that owns the access; writes return 0
    assign bus.inst_rvalid = !rst && resp && (owner == OWN_INST);
    assign bus.data_rvalid = !rst && resp && (owner == OWN_DATA);
    assign bus.inst_rdata  = (bus.inst_rvalid && !wr_q) ? bus.sram_rdata : 32'd0;
    assign bus.data_rdata  = (bus.data_rvalid && !wr_q) ? bus.sram_rdata : 32'd0;

    // Stall while a requester is blocked or an access is still in flight
    assign bus.stallreq = !rst && ((bus.inst_req && !inst_win) ||
                                   (bus.data_req && !data_win) ||
                                   ((state == BUSY) && !resp));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: one instance with LATENCY=1 and
// one with LATENCY=3, both with MAX_DATA_RUN=2.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    mem_port_arbiter_if if_a ();
    mem_port_arbiter_if if_b ();

    mem_port_arbiter #(.LATENCY(1), .MAX_DATA_RUN(2)) dut_a (
        .clk(clk), .rst(rst_a), .bus(if_a.slave)
    );
    mem_port_arbiter #(.LATENCY(3), .MAX_DATA_RUN(2)) dut_b (
        .clk(clk), .rst(rst_b), .bus(if_b.slave)
    );

    int checks = 0;
    int fails  = 0;

    // SRAM model: read data = address + 0x100, delayed by the instance latency
    logic [31:0] pa;
    logic [31:0] pb0, pb1, pb2;
    always @(posedge clk) begin
        pa  <= if_a.sram_en ? (if_a.sram_addr + 32'h100) : 32'h0;
        pb0 <= if_b.sram_en ? (if_b.sram_addr + 32'h100) : 32'h0;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign if_a.sram_rdata = pa;
    assign if_b.sram_rdata = pb2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a;
        if_a.inst_req = 0; if_a.inst_addr = 0;
        if_a.data_req = 0; if_a.data_we = 0; if_a.data_addr = 0; if_a.data_wdata = 0;
    endtask

    task automatic clear_b;
        if_b.inst_req = 0; if_b.inst_addr = 0;
        if_b.data_req = 0; if_b.data_we = 0; if_b.data_addr = 0; if_b.data_wdata = 0;
    endtask

    task automatic test_reset;
        logic [139:0] outs;
        rst_a = 1; rst_b = 1;
        clear_a(); clear_b();
        tick();
        if_a.inst_req = 1; if_a.data_req = 1; if_a.data_we = 4'hF;
        if_a.data_addr = 32'h44; if_a.data_wdata = 32'h1234;
        if_b.inst_req = 1; if_b.inst_addr = 32'h88;
        #1;
        outs = {if_a.inst_gnt, if_a.inst_rvalid, if_a.inst_rdata, if_a.data_gnt,
                if_a.data_rvalid, if_a.data_rdata, if_a.sram_en, if_a.sram_wen,
                if_a.sram_addr, if_a.sram_wdata, if_a.stallreq};
        checks++;
        if (outs !== '0) begin
            fails++; $display("FAIL reset_outputs_a: got %h expected 0", outs);
        end
        checks++;
        if ({if_b.inst_gnt, if_b.sram_en, if_b.sram_addr, if_b.stallreq, if_b.inst_rvalid} !== '0) begin
            fails++; $display("FAIL reset_outputs_b: gnt=%b en=%b addr=%h stall=%b expected all 0",
                              if_b.inst_gnt, if_b.sram_en, if_b.sram_addr, if_b.stallreq);
        end
        tick();
        clear_a(); clear_b();
        tick();
        rst_a = 0; rst_b = 0;
        tick();
    endtask

    // LATENCY=1 fetch stream at 0x0/0x4/0x8
    task automatic test_fetch_stream;
        logic        eg, erv;
        logic [31:0] erd, ead;
        for (int i = 0; i < 5; i++) begin
            tick();
            if_a.inst_req  = (i < 3);
            if_a.inst_addr = (i < 3) ? 32'(4 * i) : 32'h0;
            #1;
            eg  = (i < 3);
            erv = (i >= 1) && (i <= 3);
            erd = erv ? 32'(32'h100 + 4 * (i - 1)) : 32'h0;
            ead = eg ? 32'(4 * i) : 32'h0;
            checks++;
            if (if_a.inst_gnt !== eg) begin
                fails++; $display("FAIL fetch_gnt[%0d]: got %b expected %b", i, if_a.inst_gnt, eg);
            end
            checks++;
            if (if_a.sram_addr !== ead || if_a.sram_en !== eg) begin
                fails++; $display("FAIL fetch_sram[%0d]: en=%b addr=%h expected en=%b addr=%h",
                                  i, if_a.sram_en, if_a.sram_addr, eg, ead);
            end
            checks++;
            if (if_a.inst_rvalid !== erv || if_a.inst_rdata !== erd) begin
                fails++; $display("FAIL fetch_rsp[%0d]: rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                                  i, if_a.inst_rvalid, if_a.inst_rdata, erv, erd);
            end
            checks++;
            if (if_a.stallreq !== 1'b0) begin
                fails++; $display("FAIL fetch_stall[%0d]: got %b expected 0", i, if_a.stallreq);
            end
        end
        clear_a();
        tick();
    endtask

    // Data and fetch rise together: data first, fetch in data response cycle
    task automatic test_simultaneous;
        tick();
        if_a.inst_req = 1; if_a.inst_addr = 32'h40;
        if_a.data_req = 1; if_a.data_we = 0; if_a.data_addr = 32'h1000;
        if_a.data_wdata = 32'h5555_5555;
        #1;
        checks++;
        if (if_a.data_gnt !== 1'b1 || if_a.inst_gnt !== 1'b0) begin
            fails++; $display("FAIL simul_first: data_gnt=%b inst_gnt=%b expected 1 0",
                              if_a.data_gnt, if_a.inst_gnt);
        end
        checks++;
        if (if_a.stallreq !== 1'b1 || if_a.sram_addr !== 32'h1000) begin
            fails++; $display("FAIL simul_blocked: stall=%b addr=%h expected 1 00001000",
                              if_a.stallreq, if_a.sram_addr);
        end
        tick();
        if_a.data_req = 0;
        #1;
        checks++;
        if (if_a.data_rvalid !== 1'b1 || if_a.data_rdata !== 32'h1100) begin
            fails++; $display("FAIL simul_data_rsp: rvalid=%b rdata=%h expected 1 00001100",
                              if_a.data_rvalid, if_a.data_rdata);
        end
        checks++;
        if (if_a.inst_gnt !== 1'b1 || if_a.sram_addr !== 32'h40 ||
            if_a.sram_wen !== 4'd0 || if_a.sram_wdata !== 32'd0 || if_a.stallreq !== 1'b0) begin
            fails++; $display("FAIL simul_inst_gnt: gnt=%b addr=%h wen=%h wdata=%h stall=%b expected 1 40 0 0 0",
                              if_a.inst_gnt, if_a.sram_addr, if_a.sram_wen, if_a.sram_wdata, if_a.stallreq);
        end
        tick();
        if_a.inst_req = 0;
        #1;
        checks++;
        if (if_a.inst_rvalid !== 1'b1 || if_a.inst_rdata !== 32'h140 || if_a.data_rvalid !== 1'b0) begin
            fails++; $display("FAIL simul_inst_rsp: rvalid=%b rdata=%h data_rvalid=%b expected 1 140 0",
                              if_a.inst_rvalid, if_a.inst_rdata, if_a.data_rvalid);
        end
        clear_a();
        tick();
    endtask

    // Both held: expected grant order D,D,I,D,D
    task automatic test_fairness;
        logic [5:0] exp_d;
        logic [5:0] exp_i;
        exp_d = 6'b011011;
        exp_i = 6'b000100;
        for (int i = 0; i < 6; i++) begin
            tick();
            if_a.data_req  = (i < 5); if_a.data_we = 0;
            if_a.data_addr = 32'h200 + 32'(i);
            if_a.inst_req  = (i < 3); if_a.inst_addr = 32'h300;
            #1;
            checks++;
            if (if_a.data_gnt !== exp_d[i] || if_a.inst_gnt !== exp_i[i]) begin
                fails++; $display("FAIL fair_order[%0d]: data_gnt=%b inst_gnt=%b expected %b %b",
                                  i, if_a.data_gnt, if_a.inst_gnt, exp_d[i], exp_i[i]);
            end
        end
        checks++;
        if (if_a.data_rvalid !== 1'b1 || if_a.data_rdata !== 32'h304) begin
            fails++; $display("FAIL fair_last_rsp: rvalid=%b rdata=%h expected 1 00000304",
                              if_a.data_rvalid, if_a.data_rdata);
        end
        clear_a();
        tick();
    endtask

    // Store: byte enables and data reach the SRAM, response carries 0
    task automatic test_store;
        tick();
        if_a.data_req = 1; if_a.data_we = 4'b0011;
        if_a.data_addr = 32'h20; if_a.data_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (if_a.data_gnt !== 1'b1 || if_a.sram_en !== 1'b1 || if_a.sram_wen !== 4'b0011 ||
            if_a.sram_addr !== 32'h20 || if_a.sram_wdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL store_drive: gnt=%b en=%b wen=%b addr=%h wdata=%h expected 1 1 0011 20 deadbeef",
                              if_a.data_gnt, if_a.sram_en, if_a.sram_wen, if_a.sram_addr, if_a.sram_wdata);
        end
        tick();
        clear_a();
        #1;
        checks++;
        if (if_a.data_rvalid !== 1'b1 || if_a.data_rdata !== 32'h0) begin
            fails++; $display("FAIL store_ack: rvalid=%b rdata=%h expected 1 0",
                              if_a.data_rvalid, if_a.data_rdata);
        end
        checks++;
        if (if_a.sram_en !== 1'b0 || if_a.sram_wen !== 4'd0 || if_a.sram_wdata !== 32'd0) begin
            fails++; $display("FAIL store_idle_sram: en=%b wen=%b wdata=%h expected 0 0 0",
                              if_a.sram_en, if_a.sram_wen, if_a.sram_wdata);
        end
        tick();
    endtask

    // LATENCY=3: two stall cycles, data waits, then back-to-back data grant
    task automatic test_latency_stall;
        logic [6:0] exp_st;
        exp_st = 7'b0110110;
        tick();
        if_b.inst_req = 1; if_b.inst_addr = 32'h80;
        #1;
        checks++;
        if (if_b.inst_gnt !== 1'b1 || if_b.stallreq !== 1'b0) begin
            fails++; $display("FAIL lat_grant: gnt=%b stall=%b expected 1 0", if_b.inst_gnt, if_b.stallreq);
        end
        for (int i = 1; i < 7; i++) begin
            tick();
            if_b.inst_req  = 0;
            if_b.data_req  = (i <= 3); if_b.data_addr = 32'h90;
            #1;
            checks++;
            if (if_b.stallreq !== exp_st[i]) begin
                fails++; $display("FAIL lat_stall[%0d]: got %b expected %b", i, if_b.stallreq, exp_st[i]);
            end
            checks++;
            if (if_b.data_gnt !== (i == 3)) begin
                fails++; $display("FAIL lat_data_gnt[%0d]: got %b expected %b", i, if_b.data_gnt, (i == 3));
            end
            checks++;
            if (if_b.inst_rvalid !== (i == 3) || if_b.inst_rdata !== ((i == 3) ? 32'h180 : 32'h0)) begin
                fails++; $display("FAIL lat_inst_rsp[%0d]: rvalid=%b rdata=%h", i, if_b.inst_rvalid, if_b.inst_rdata);
            end
        end
        checks++;
        if (if_b.data_rvalid !== 1'b1 || if_b.data_rdata !== 32'h190) begin
            fails++; $display("FAIL lat_data_rsp: rvalid=%b rdata=%h expected 1 00000190",
                              if_b.data_rvalid, if_b.data_rdata);
        end
        clear_b();
        tick();
    endtask

    // Reset the cycle after a LATENCY=3 grant: access dropped, then normal service
    task automatic test_reset_mid_access;
        tick();
        if_b.inst_req = 1; if_b.inst_addr = 32'hA0;
        #1;
        checks++;
        if (if_b.inst_gnt !== 1'b1) begin
            fails++; $display("FAIL rstmid_grant: got %b expected 1", if_b.inst_gnt);
        end
        tick();
        if_b.inst_req = 0; rst_b = 1;
        #1;
        checks++;
        if ({if_b.stallreq, if_b.inst_rvalid, if_b.sram_en} !== 3'b000) begin
            fails++; $display("FAIL rstmid_in_reset: stall=%b rvalid=%b en=%b expected 0 0 0",
                              if_b.stallreq, if_b.inst_rvalid, if_b.sram_en);
        end
        for (int i = 2; i < 5; i++) begin
            tick();
            rst_b = 0;
            #1;
            checks++;
            if (if_b.inst_rvalid !== 1'b0 || if_b.stallreq !== 1'b0) begin
                fails++; $display("FAIL rstmid_dropped[%0d]: rvalid=%b stall=%b expected 0 0",
                                  i, if_b.inst_rvalid, if_b.stallreq);
            end
        end
        tick();
        if_b.inst_req = 1; if_b.inst_addr = 32'hB0;
        #1;
        checks++;
        if (if_b.inst_gnt !== 1'b1 || if_b.sram_addr !== 32'hB0) begin
            fails++; $display("FAIL rstmid_fresh_gnt: gnt=%b addr=%h expected 1 b0", if_b.inst_gnt, if_b.sram_addr);
        end
        tick(); if_b.inst_req = 0;
        tick();
        tick();
        checks++;
        if (if_b.inst_rvalid !== 1'b1 || if_b.inst_rdata !== 32'h1B0) begin
            fails++; $display("FAIL rstmid_fresh_rsp: rvalid=%b rdata=%h expected 1 000001b0",
                              if_b.inst_rvalid, if_b.inst_rdata);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch_stream();
        test_simultaneous();
        test_fairness();
        test_store();
        test_latency_stall();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
